// File: rtl/aidan_mcnay_frame_sipo.sv
// Serial-in/parallel-out frame receiver with a valid/ready holding register.
// Optional even-parity checking is compiled in with AIDAN_MCNAY_FRAME_SIPO_PARITY_EN.
module aidan_mcnay_frame_sipo #(
  parameter int nbits     = 16,
  parameter int msb_first = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       data_in,
  input  logic                       clear,
  output logic [nbits-1:0]           data_out,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic                       overrun,
  output logic                       parity_err,
  output logic [$clog2(nbits+1)-1:0] bit_count
);

  localparam int CW = $clog2(nbits + 1);
`ifdef AIDAN_MCNAY_FRAME_SIPO_PARITY_EN
  localparam int FRAME_LEN = nbits + 1;
`else
  localparam int FRAME_LEN = nbits;
`endif

  logic [nbits-1:0] shift_reg, shift_next;
  logic [nbits-1:0] shifted;
  logic [CW-1:0]    count_reg, count_next;
  logic [nbits-1:0] data_out_reg, data_out_next;
  logic             out_val_reg, out_val_next;
  logic             overrun_reg, overrun_next;
  logic             parity_err_reg, parity_err_next;
  logic             accept;
  logic             complete;
  logic             payload_bit;
  logic [nbits-1:0] frame_data;

  // Shift path: new bit enters at the LSB (msb_first) or at the MSB (lsb-first).
  generate
    for (genvar gi = 0; gi < nbits; gi++) begin : g_shift
      if (msb_first != 0) begin : g_msb
        if (gi == 0) begin : g_in
          assign shifted[gi] = data_in;
        end else begin : g_mv
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == nbits - 1) begin : g_in
          assign shifted[gi] = data_in;
        end else begin : g_mv
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  assign accept   = en && !clear;
  assign complete = accept && (count_reg == CW'(FRAME_LEN - 1));

`ifdef AIDAN_MCNAY_FRAME_SIPO_PARITY_EN
  logic parity_acc_reg, parity_acc_next;

  // The trailing parity bit completes the frame but never enters the payload.
  assign payload_bit = (int'(count_reg) < nbits);
  assign frame_data  = shift_reg;

  always_comb begin
    parity_acc_next = parity_acc_reg;
    parity_err_next = parity_err_reg;
    if (clear || complete) begin
      parity_acc_next = 1'b0;
    end else if (accept) begin
      parity_acc_next = parity_acc_reg ^ data_in;
    end
    if (complete && (!out_val_reg || out_rdy)) begin
      parity_err_next = parity_acc_reg ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_acc_reg <= 1'b0;
    end else begin
      parity_acc_reg <= parity_acc_next;
    end
  end
`else
  assign payload_bit     = 1'b1;
  assign frame_data      = shifted;
  assign parity_err_next = 1'b0;
`endif

  // Shift register and bit counter.
  always_comb begin
    shift_next = shift_reg;
    count_next = count_reg;
    if (clear || complete) begin
      shift_next = '0;
      count_next = '0;
    end else if (accept) begin
      count_next = count_reg + CW'(1);
      if (payload_bit) begin
        shift_next = shifted;
      end
    end
  end

  // Holding register: a completed frame is dropped only when the slot is full and not draining.
  always_comb begin
    data_out_next = data_out_reg;
    out_val_next  = out_val_reg;
    overrun_next  = overrun_reg;
    if (complete) begin
      if (!out_val_reg || out_rdy) begin
        data_out_next = frame_data;
        out_val_next  = 1'b1;
      end else begin
        overrun_next  = 1'b1;
      end
    end else if (out_val_reg && out_rdy) begin
      out_val_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg      <= '0;
      count_reg      <= '0;
      data_out_reg   <= '0;
      out_val_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      shift_reg      <= shift_next;
      count_reg      <= count_next;
      data_out_reg   <= data_out_next;
      out_val_reg    <= out_val_next;
      overrun_reg    <= overrun_next;
      parity_err_reg <= parity_err_next;
    end
  end

  assign data_out   = data_out_reg;
  assign out_val    = out_val_reg;
  assign overrun    = overrun_reg;
  assign parity_err = parity_err_reg;
  assign bit_count  = count_reg;

endmodule

// File: tb/tb_aidan_mcnay_frame_sipo.sv
// Directed bench for aidan_mcnay_frame_sipo: MSB-first and LSB-first instances share stimulus.
// Parity cases run only when AIDAN_MCNAY_FRAME_SIPO_PARITY_EN is defined.
module tb_aidan_mcnay_frame_sipo;

  localparam int NB = 16;
`ifdef AIDAN_MCNAY_FRAME_SIPO_PARITY_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif

  logic          clk = 1'b0;
  logic          reset, en, data_in, clear, out_rdy;
  logic [NB-1:0] data_out_a, data_out_b;
  logic          out_val_a, out_val_b, overrun_a, overrun_b, perr_a, perr_b;
  logic [4:0]    cnt_a, cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aidan_mcnay_frame_sipo #(.nbits(NB), .msb_first(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clear(clear),
    .data_out(data_out_a), .out_val(out_val_a), .out_rdy(out_rdy),
    .overrun(overrun_a), .parity_err(perr_a), .bit_count(cnt_a)
  );

  aidan_mcnay_frame_sipo #(.nbits(NB), .msb_first(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clear(clear),
    .data_out(data_out_b), .out_val(out_val_b), .out_rdy(out_rdy),
    .overrun(overrun_b), .parity_err(perr_b), .bit_count(cnt_b)
  );

  typedef struct {
    logic [15:0] payload;
    logic        drain;
    logic        rdy_last;
    logic [15:0] exp_data;
    logic        exp_val;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = v[15-k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input logic rdy);
    out_rdy = rdy;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
  endtask

  // Sends v[n-1] first down to v[0]; out_rdy is asserted only with the final bit.
  task automatic send_bits(input logic [16:0] v, input int n, input logic rdy_last);
    for (int k = n - 1; k >= 0; k--) begin
      en      = 1'b1;
      data_in = v[k];
      out_rdy = (k == 0) ? rdy_last : 1'b0;
      @(posedge clk);
      #1;
      en      = 1'b0;
      data_in = 1'b0;
      out_rdy = 1'b0;
    end
  endtask

  function automatic logic [16:0] frame_of(input logic [15:0] p);
`ifdef AIDAN_MCNAY_FRAME_SIPO_PARITY_EN
    return {p, ^p};
`else
    return {1'b0, p};
`endif
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] d, input logic v, input logic o);
    chk({tag, " data_a"}, 32'(data_out_a), 32'(d));
    chk({tag, " data_b"}, 32'(data_out_b), 32'(rev16(d)));
    chk({tag, " val"},    32'(out_val_a),  32'(v));
    chk({tag, " val_b"},  32'(out_val_b),  32'(v));
    chk({tag, " ovr"},    32'(overrun_a),  32'(o));
    chk({tag, " cnt"},    32'(cnt_a),      32'd0);
    chk({tag, " perr"},   32'(perr_a),     32'd0);
  endtask

  initial begin
    logic [16:0] fr;

    reset = 1'b1; en = 1'b0; data_in = 1'b0; clear = 1'b0; out_rdy = 1'b0;
    vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{16'h3333, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0};
    vecs[2] = '{16'h1111, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0};
    vecs[3] = '{16'h2222, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1};
    vecs[4] = '{16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1};
    vecs[5] = '{16'h0F0F, 1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b1};

    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check_frame("reset", 16'h0000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].drain) idle(1'b1);
      fr = frame_of(vecs[i].payload);
      send_bits(fr >> 1, FL - 1, 1'b0);
      if (i == 0) begin
        chk("pre_last val", 32'(out_val_a), 32'd0);
        chk("pre_last cnt", 32'(cnt_a), 32'(FL - 1));
      end
      send_bits(fr & 17'd1, 1, vecs[i].rdy_last);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_val, vecs[i].exp_ovr);
      $display("vec%0d payload=%h data_a=%h data_b=%h val=%0d ovr=%0d",
               i, vecs[i].payload, data_out_a, data_out_b, out_val_a, overrun_a);
    end

    // Drain with no completion: out_val drops, data and overrun persist.
    idle(1'b1);
    chk("drain val", 32'(out_val_a), 32'd0);
    chk("drain ovr", 32'(overrun_a), 32'd1);
    chk("drain data", 32'(data_out_a), 32'h0F0F);
    $display("drain val=%0d ovr=%0d data=%h", out_val_a, overrun_a, data_out_a);

    // Partial frame, en=0 hold, then clear with en=1.
    send_bits(17'h7F, 7, 1'b0);
    chk("partial cnt", 32'(cnt_a), 32'd7);
    data_in = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("en0 hold cnt", 32'(cnt_a), 32'd7);
    clear = 1'b1; en = 1'b1; data_in = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; en = 1'b0; data_in = 1'b0;
    chk("clear cnt", 32'(cnt_a), 32'd0);
    chk("clear val", 32'(out_val_a), 32'd0);
    chk("clear ovr", 32'(overrun_a), 32'd1);
    $display("clear cnt=%0d val=%0d ovr=%0d", cnt_a, out_val_a, overrun_a);
    send_bits(frame_of(16'h1234), FL, 1'b0);
    check_frame("after_clear", 16'h1234, 1'b1, 1'b1);
    $display("after_clear data_a=%h data_b=%h", data_out_a, data_out_b);

    // Reset mid-frame.
    send_bits(17'h1FF, 9, 1'b0);
    chk("mid cnt", 32'(cnt_a), 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_frame("midreset", 16'h0000, 1'b0, 1'b0);
    chk("midreset ovr_b", 32'(overrun_b), 32'd0);
    $display("midreset data=%h val=%0d ovr=%0d cnt=%0d", data_out_a, out_val_a, overrun_a, cnt_a);

`ifdef AIDAN_MCNAY_FRAME_SIPO_PARITY_EN
    send_bits({16'h0001, 1'b1}, 17, 1'b0);
    chk("par_ok data", 32'(data_out_a), 32'h0001);
    chk("par_ok perr", 32'(perr_a), 32'd0);
    $display("parity good perr=%0d", perr_a);
    idle(1'b1);
    send_bits({16'h0001, 1'b0}, 17, 1'b0);
    chk("par_bad data", 32'(data_out_a), 32'h0001);
    chk("par_bad perr", 32'(perr_a), 32'd1);
    chk("par_bad perr_b", 32'(perr_b), 32'd1);
    $display("parity bad perr=%0d", perr_a);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aidan_mcnay_frame_sipo.md
AIDAN_MCNAY_FRAME_SIPO -- requirements
Module: aidan_mcnay_frame_sipo

Interface
REQ-001 SHALL have parameter nbits, default 16, frame payload width in bits (legal range 2..64).
REQ-002 SHALL have parameter msb_first, default 1, 1 = first received bit lands in data_out[nbits-1], 0 = first received bit lands in data_out[0].
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, data_in carries a valid serial bit this cycle.
REQ-006 SHALL have port data_in, input, 1, serial data bit.
REQ-007 SHALL have port clear, input, 1, abandon partial frame and restart bit count.
REQ-008 SHALL have port data_out, output, nbits, last completed frame (holding register).
REQ-009 SHALL have port out_val, output, 1, data_out holds an unconsumed frame.
REQ-010 SHALL have port out_rdy, input, 1, consumer accepts data_out when out_val && out_rdy.
REQ-011 SHALL have port overrun, output, 1, sticky: a completed frame was dropped.
REQ-012 SHALL have port parity_err, output, 1, parity status of data_out frame (see Configuration).
REQ-013 SHALL have port bit_count, output, clog2(nbits+1), bits accepted in current partial frame.

Function
REQ-014 SHALL accept one bit per cycle with en=1 and clear=0 into an internal shift register, incrementing bit_count.
REQ-015 SHALL treat the bit that brings the count to frame length L (L=nbits, or nbits+1 with parity) as frame completion; bit_count returns to 0 the same edge.
REQ-016 SHALL, on completion with out_val=0, load the full frame (including the completing bit) into data_out and set out_val next cycle; latency last bit -> out_val = 1 cycle.
REQ-017 SHALL, on completion with out_val=1 and out_rdy=1 the same cycle, overwrite data_out with the new frame and keep out_val=1.
REQ-018 SHALL, on completion with out_val=1 and out_rdy=0, discard the new frame, keep data_out unchanged, and set overrun=1.
REQ-019 SHALL clear out_val on out_val && out_rdy when no frame completes that cycle; data_out value retained.
REQ-020 SHALL hold data_out stable while out_val=1 except per REQ-017.
REQ-021 SHALL, on clear=1, zero the shift register and bit_count and discard any en bit that cycle; data_out, out_val, overrun unaffected.
REQ-022 SHALL ignore data_in when en=0; shift register and count hold.
REQ-023 SHALL clear overrun only by reset.
REQ-024 SHALL not change bit order by msb_first except placement per REQ-002; msb_first=1 matches the legacy SIPO ordering.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set shift register 0, bit_count 0, data_out 0, out_val 0, overrun 0, parity_err 0.
REQ-026 SHALL give reset priority over clear, en and out_rdy; a frame in progress is lost.

Configuration
REQ-027 SHALL compile even-parity support only when macro AIDAN_MCNAY_FRAME_SIPO_PARITY_EN is defined.
REQ-028 SHALL, with the macro defined, expect nbits payload bits then one parity bit; parity_err is registered with data_out and is 1 when XOR of payload and parity bit is 1; parity bit not in data_out.
REQ-029 SHALL, without the macro, use L=nbits and drive parity_err constant 0; port list unchanged.

Verification
REQ-030 SHALL cover: nbits=16, msb_first=1, shift 0xA5C3 MSB-first with en=1 16 cycles -> out_val=1 one cycle after last bit, data_out=0xA5C3, bit_count=0.
REQ-031 SHALL cover: msb_first=0, same bit stream -> data_out=0xC3A5 bit-reversed (0xC3A5 reversed = 16'hA5C3 reordered), verified against first bit at data_out[0].
REQ-032 SHALL cover: out_rdy=0, two frames 0x1111 then 0x2222 -> data_out stays 0x1111, overrun=1; then out_rdy=1 -> out_val=0 next cycle, overrun stays 1.
REQ-033 SHALL cover: out_val=1, out_rdy=1 on the completion edge of 0x3333 -> data_out=0x3333, out_val stays 1, overrun=0.
REQ-034 SHALL cover: 7 bits shifted, clear=1 with en=1 -> bit_count=0; next 16 bits 0xBEEF -> data_out=0xBEEF; reset mid-frame (9 bits) -> all outputs 0.
REQ-035 SHALL cover, macro defined: payload 0x0001 + parity bit 1 -> parity_err=0; payload 0x0001 + parity 0 -> parity_err=1.
